// File: rtl/b_reg_pkg.sv
// Shared indices, reset defaults and word types for the b_reg register file.
// Feature macro B_REG_MP_BYPASS_EN is consumed by b_reg_mp, not by this package.
package b_reg_pkg;

  localparam int REG_ZERO   = 0;
  localparam int REG_GP     = 28;
  localparam int REG_SP     = 29;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_DATA_W-1:0] RST_GP_DEFAULT = 32'h1000_4000;
  localparam logic [REG_DATA_W-1:0] RST_SP_DEFAULT = 32'h7fff_fffc;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // The smallest address width that still reaches the GP and SP entries.
  function automatic bit addr_w_ok(input int addr_w);
    return (1 << addr_w) > REG_SP;
  endfunction

endpackage

// File: rtl/b_reg_scoreboard.sv
// Pending-producer scoreboard: one bit per entry, set by alloc, cleared by write or flush.
// Same-cycle alloc beats write (new producer wins); flush beats both; entry 0 never pends.
module b_reg_scoreboard
  import b_reg_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   i_sys_clock,
  input  logic                   i_sys_reset,
  input  logic                   i_alloc_en,
  input  logic [ADDR_W-1:0]      i_alloc_addr,
  input  logic                   i_regwr,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_flush,
  output logic [(1<<ADDR_W)-1:0] o_pending
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (i_regwr) begin
      pending_d[i_wr_addr] = 1'b0;
    end
    if (i_alloc_en) begin
      pending_d[i_alloc_addr] = 1'b1;
    end
    if (i_flush) begin
      pending_d = '0;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign o_pending = pending_q;

endmodule

// File: rtl/b_reg_mp.sv
// Multi-read-port register file with zero entry, GP/SP reset values and a producer scoreboard.
// Define B_REG_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module b_reg_mp
  import b_reg_pkg::*;
#(
  parameter int                DATA_W = REG_DATA_W,
  parameter int                ADDR_W = REG_ADDR_W,
  parameter int                NUM_RD = 2,
  parameter logic [DATA_W-1:0] RST_GP = DATA_W'(RST_GP_DEFAULT),
  parameter logic [DATA_W-1:0] RST_SP = DATA_W'(RST_SP_DEFAULT)
) (
  input  logic                           i_sys_clock,
  input  logic                           i_sys_reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_b_reg_read_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  o_b_reg_read_data,
  output logic [NUM_RD-1:0]              o_b_reg_busy,
  input  logic                           i_b_reg_regwr,
  input  logic [ADDR_W-1:0]              i_b_reg_wr_addr,
  input  logic [DATA_W-1:0]              i_b_reg_wr_data,
  input  logic                           i_b_reg_alloc_en,
  input  logic [ADDR_W-1:0]              i_b_reg_alloc_addr,
  input  logic                           i_b_reg_flush
);

  localparam int DEPTH = 1 << ADDR_W;

  if (!addr_w_ok(ADDR_W)) begin : g_addr_w_check
    $error("b_reg_mp: ADDR_W must be at least 5 to hold the GP/SP entries");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_num_rd_check
    $error("b_reg_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              wr_en;

  assign wr_en = i_b_reg_regwr && (i_b_reg_wr_addr != '0);

  b_reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .i_sys_clock  (i_sys_clock),
    .i_sys_reset  (i_sys_reset),
    .i_alloc_en   (i_b_reg_alloc_en),
    .i_alloc_addr (i_b_reg_alloc_addr),
    .i_regwr      (i_b_reg_regwr),
    .i_wr_addr    (i_b_reg_wr_addr),
    .i_flush      (i_b_reg_flush),
    .o_pending    (pending)
  );

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge i_sys_clock or posedge i_sys_reset) begin
    if (i_sys_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == REG_GP) begin
          regs_q[i] <= RST_GP;
        end else if (i == REG_SP) begin
          regs_q[i] <= RST_SP;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else if (wr_en) begin
      regs_q[i_b_reg_wr_addr] <= i_b_reg_wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      o_b_reg_read_data[p] = '0;
      o_b_reg_busy[p]      = 1'b0;
      if (i_b_reg_read_addr[p] != '0) begin
        o_b_reg_read_data[p] = regs_q[i_b_reg_read_addr[p]];
        o_b_reg_busy[p]      = pending[i_b_reg_read_addr[p]];
`ifdef B_REG_MP_BYPASS_EN
        // The in-flight write resolves the producer, so the reader need not wait.
        if (wr_en && (i_b_reg_wr_addr == i_b_reg_read_addr[p])) begin
          o_b_reg_read_data[p] = i_b_reg_wr_data;
          o_b_reg_busy[p]      = 1'b0;
        end
`endif
      end
    end
  end

endmodule
